// File: rtl/mips_muldiv_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_muldiv_unit_if : operation request / Hi-Lo result bus of the muldiv   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUctl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (
    output start, ALUctl, A, B,
    input  Hi, Lo, Busy, Done, DivZero
  );

  modport slave (
    input  start, ALUctl, A, B,
    output Hi, Lo, Busy, Done, DivZero
  );
endinterface
`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_muldiv_unit : radix-2 iterative MULT/MULTU/DIV/DIVU into Hi/Lo        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic        clock,
  input  wire logic        reset,
  mips_muldiv_unit_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_mag_q, b_mag_d;
  logic              is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic              busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;

  logic              w_legal, w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]  w_a_mag, w_b_mag;
  logic [WIDTH:0]    w_mul_sum, w_div_shift, w_div_diff;
  logic              w_div_ok;
  logic [WIDTH-1:0]  w_step_hi, w_step_lo, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_legal  = bus.start && (bus.ALUctl[3:2] == 2'b10);
  assign w_signed = bus.ALUctl[0];
  assign w_a_neg  = w_signed & bus.A[WIDTH-1];
  assign w_b_neg  = w_signed & bus.B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -bus.A : bus.A;
  assign w_b_mag  = w_b_neg ? -bus.B : bus.B;

  // Multiply: {acc_hi,acc_lo} holds partial product over the shifting multiplier.
  assign w_mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_mag_q} : '0);

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  assign w_div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, b_mag_q};
  assign w_div_ok    = ~w_div_diff[WIDTH];

  assign w_step_hi = is_div_q ? (w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0])
                              : w_mul_sum[WIDTH:1];
  assign w_step_lo = is_div_q ? {acc_lo_q[WIDTH-2:0], w_div_ok}
                              : {w_mul_sum[0], acc_lo_q[WIDTH-1:1]};

  assign w_prod     = {w_step_hi, w_step_lo};
  assign w_prod_fix = neg_q ? -w_prod : w_prod;
  assign w_quo      = neg_q ? -w_step_lo : w_step_lo;
  assign w_rem      = neg_rem_q ? -w_step_hi : w_step_hi;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    b_mag_d    = b_mag_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (w_legal) begin
          is_div_d  = bus.ALUctl[1];
          neg_d     = w_a_neg ^ w_b_neg;
          neg_rem_d = w_a_neg;
          acc_hi_d  = '0;
          acc_lo_d  = w_a_mag;
          b_mag_d   = w_b_mag;
          cnt_d     = '0;
          if (bus.ALUctl[1] && (bus.B == '0)) begin
            state_d    = S_DONE;
            hi_d       = bus.A;
            lo_d       = '1;
            div_zero_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_hi_d = w_step_hi;
        acc_lo_d = w_step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d    = S_DONE;
          hi_d       = is_div_q ? w_rem : w_prod_fix[2*WIDTH-1:WIDTH];
          lo_d       = is_div_q ? w_quo : w_prod_fix[WIDTH-1:0];
          div_zero_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      b_mag_q    <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      b_mag_q    <= b_mag_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DivZero = div_zero_q;
endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mips_muldiv_unit : directed scoreboard bench for mips_muldiv_unit       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_mips_muldiv_unit;
  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          busy;
  } exp_t;

  exp_t sb[$];

  mips_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  mips_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issue one operation, optionally disturbing inputs mid-RUN, and score the result.
  task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input bit disturb);
    exp_t e;
    int   lat;
    int   busy_n;
    bit   got;
    e.tag  = tag;
    e.hi   = eh;
    e.lo   = el;
    e.dz   = edz;
    e.lat  = edz ? 1 : WIDTH + 1;
    e.busy = edz ? 0 : WIDTH;
    sb.push_back(e);
    bus.ALUctl = ctl;
    bus.A      = a;
    bus.B      = b;
    bus.start  = 1'b1;
    lat    = 0;
    busy_n = 0;
    got    = 1'b0;
    while (!got && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
      if (lat == 1) bus.start = 1'b0;
      if (disturb && lat == 5) begin
        bus.start = 1'b1;
        bus.A     = 32'd5;
        bus.B     = 32'd5;
      end
      if (disturb && lat == 6) bus.start = 1'b0;
      if (bus.Busy) busy_n++;
      if (bus.Done) got = 1'b1;
    end
    e = sb.pop_front();
    check({e.tag, "_latency"}, 64'(lat), 64'(e.lat));
    check({e.tag, "_busy_cycles"}, 64'(busy_n), 64'(e.busy));
    check({e.tag, "_hi"}, 64'(bus.Hi), 64'(e.hi));
    check({e.tag, "_lo"}, 64'(bus.Lo), 64'(e.lo));
    check({e.tag, "_divzero"}, 64'(bus.DivZero), 64'(e.dz));
    @(posedge clock);
    #1;
    check({e.tag, "_done_one_cycle"}, 64'(bus.Done), 64'd0);
    check({e.tag, "_idle_not_busy"}, 64'(bus.Busy), 64'd0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.ALUctl = 4'b0000;
    bus.A      = '0;
    bus.B      = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_hi",   64'(bus.Hi),      64'd0);
    check("reset_lo",   64'(bus.Lo),      64'd0);
    check("reset_busy", 64'(bus.Busy),    64'd0);
    check("reset_done", 64'(bus.Done),    64'd0);
    check("reset_dz",   64'(bus.DivZero), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    run_op("multu_12x10",  4'b1000, 32'd12, 32'd10, 32'd0, 32'd120, 1'b0, 1'b0);
    run_op("mult_m3x7",    4'b1001, -32'sd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
    run_op("multu_max",    4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    run_op("div_m7_2",     4'b1011, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("div_7_m2",     4'b1011, 32'd7, -32'sd2, 32'd1, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divu_100_7",   4'b1010, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
    run_op("div_minneg",   4'b1011, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b0);
    run_op("divu_by_zero", 4'b1010, 32'd12, 32'd0, 32'd12, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("multu_2x3",    4'b1000, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0);
    run_op("div_by_zero",  4'b1011, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("multu_disturb", 4'b1000, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 1'b0, 1'b1);

    // Illegal opcode in IDLE: nothing may change for a full operation's worth of cycles.
    begin
      int seen_done;
      int seen_busy;
      seen_done = 0;
      seen_busy = 0;
      bus.ALUctl = 4'b0010;
      bus.A      = 32'd9;
      bus.B      = 32'd9;
      bus.start  = 1'b1;
      for (int i = 0; i < WIDTH + 4; i++) begin
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        if (bus.Done) seen_done++;
        if (bus.Busy) seen_busy++;
      end
      check("illegal_no_done", 64'(seen_done), 64'd0);
      check("illegal_no_busy", 64'(seen_busy), 64'd0);
      check("illegal_hi_hold", 64'(bus.Hi), 64'd1);
      check("illegal_lo_hold", 64'(bus.Lo), 64'd0);
    end

    // Asynchronous reset ten cycles into a multiply.
    bus.ALUctl = 4'b1000;
    bus.A      = 32'h00012345;
    bus.B      = 32'h00006789;
    bus.start  = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    check("pre_reset_busy", 64'(bus.Busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(bus.Busy), 64'd0);
    check("abort_done", 64'(bus.Done), 64'd0);
    check("abort_hi",   64'(bus.Hi),   64'd0);
    check("abort_lo",   64'(bus.Lo),   64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    run_op("multu_5x5", 4'b1000, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0, 1'b0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Multi-cycle arithmetic responder on the same ALUctl/A/B operation interface the single-cycle MIPSALU serves.
- Executes the operations the single-cycle ALU cannot: MULT, MULTU, DIV and DIVU.
- Delivers results into Hi/Lo registers and uses a start/busy/done handshake toward the datapath control.
- Sits beside MIPSALU in the EX stage; the controller stalls while Busy is high.

Parameters:
- WIDTH, 32, operand and Hi/Lo width. The iteration count equals WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- ALUctl  input  4  operation code: 4'b1000 MULTU, 4'b1001 MULT, 4'b1010 DIVU, 4'b1011 DIV.
- A  input  WIDTH  multiplicand or dividend.
- B  input  WIDTH  multiplier or divisor.
- Hi  output  WIDTH  product upper half, or division remainder.
- Lo  output  WIDTH  product lower half, or division quotient.
- Busy  output  1  high while iterating.
- Done  output  1  one-cycle completion pulse.
- DivZero  output  1  set when a division had divisor 0; holds until the next completion.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; Hi=Lo=0; Busy=Done=DivZero=0; iteration counter=0.
  - Reset mid-operation aborts the operation and loses the result.
- States and transitions:
  - IDLE: on start=1 with a legal ALUctl, latch ALUctl/A/B and go to RUN.
  - Divide with B==0: go straight to DONE.
  - start with any other ALUctl code: ignored, remain IDLE, no outputs change.
  - RUN: exactly WIDTH cycles, one radix-2 step per cycle; Busy=1 throughout; then go to DONE.
  - DONE: one cycle; Done=1, Busy=0; Hi/Lo/DivZero updated on entry. Then go to IDLE.
- Start handling:
  - start is ignored in RUN and DONE.
  - The earliest new accept is the cycle after DONE.
- Latency:
  - Accept at edge k: Busy high after edges k+1..k+WIDTH, Done high after edge k+WIDTH+1.
  - Divide-by-zero: Done high after edge k+1.
- Operands:
  - Latched at accept; A/B/ALUctl changes during RUN have no effect.
  - Hi/Lo change only on entry to DONE and hold otherwise.
- Signed operations (MULT, DIV):
  - Operate on magnitudes, then apply the sign fix.
  - MULT: the full 2*WIDTH two's-complement product goes to {Hi,Lo}.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV of most-negative by -1: Lo=most-negative (0x80000000), Hi=0, no flag.
- Unsigned operations (MULTU, DIVU): straight shift-add multiply and restoring divide.
- Divide by zero (DIV or DIVU with B==0): Hi=A, Lo=all ones, DivZero=1.
- Completion flags: DivZero is cleared at any completion that is not a divide-by-zero.

Test Plan:
- Reset, then MULTU A=12 B=10 -> Busy high for 32 cycles, Done after cycle 33, Hi=0, Lo=120, DivZero=0.
- MULT A=-3 B=7 -> Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB. MULTU A=B=32'hFFFFFFFF -> Hi=32'hFFFFFFFE, Lo=32'h00000001.
- DIV A=-7 B=2 -> Lo=32'hFFFFFFFD (-3), Hi=32'hFFFFFFFF (-1). DIVU A=100 B=7 -> Lo=14, Hi=2. DIV 0x80000000 by -1 -> Lo=32'h80000000, Hi=0.
- DIVU A=12 B=0 -> Done after one cycle, DivZero=1, Hi=12, Lo=32'hFFFFFFFF. A following MULTU 2*3 then clears DivZero, Lo=6.
- start pulsed with A/B changed during RUN, and start with ALUctl=4'b0010 in IDLE -> both ignored; the original result stands and no Done pulse comes from the illegal request.
- Assert reset at cycle 10 of a MULTU -> Busy, Done, Hi and Lo all go to 0 immediately. After release, a new MULTU 5*5 completes normally with Lo=25.
